xeng_corr_apply: RTL and testbench

- Consumes the eight per-baseline correction words from the component tracker and subtracts them from the matching raw X-engine accumulator outputs.
- The raw outputs are computed with offset-binary (uint) real parts; subtracting the correction recovers the true signed correlation.
- Corrections arrive early and in bursts, so a small FIFO buffers them. Each valid X-engine output pops one correction set.
- Sits directly after the X-engine tap chain output, ahead of the long-term vector accumulator.

---
 rtl/xeng_corr_apply.sv | 118 +++++++++++
 tb/tb_xeng_corr_apply.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/xeng_corr_apply.sv
// Buffers per-baseline correction sets in a small FIFO and subtracts them from raw
// X-engine outputs, turning offset-binary accumulations into signed correlations.
module xeng_corr_apply #(
    parameter int CORR_WIDTH      = 15,
    parameter int ACC_WIDTH       = 24,
    parameter int FIFO_DEPTH_BITS = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sync,
    input  logic                          corr_vld,
    input  logic [8*CORR_WIDTH-1:0]       corr_din,
    input  logic                          xeng_vld,
    input  logic [8*ACC_WIDTH-1:0]        xeng_din,
    output logic [8*(ACC_WIDTH+1)-1:0]    dout,
    output logic                          dout_vld,
    output logic                          sync_out,
    output logic [FIFO_DEPTH_BITS:0]      fifo_level,
    output logic                          err
);
    localparam int CW    = CORR_WIDTH;
    localparam int AW    = ACC_WIDTH;
    localparam int OW    = ACC_WIDTH + 1;
    localparam int FB    = FIFO_DEPTH_BITS;
    localparam int DEPTH = 1 << FB;

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t              state_q, state_d;
    logic                err_d;
    logic [FB-1:0]       wr_q, rd_q, wr_eff, rd_eff;
    logic [FB:0]         level_q, level_eff, level_d;
    logic [8*CW-1:0]     mem [DEPTH];
    logic [1:0]          sync_pipe_q;

    logic                run_eff, empty, full, push_req, pop_req;
    logic                bypass, overflow, underflow, fault, do_push, do_pop, accept;
    logic [8*CW-1:0]     corr_sel;

    logic                s1_vld_q;
    logic [8*AW-1:0]     s1_raw_q;
    logic [8*CW-1:0]     s1_corr_q;
    logic [8*OW-1:0]     diff;
    logic [AW-1:0]       raw_f;
    logic [CW-1:0]       corr_f;

    // A sync flushes first, so the rest of that cycle sees RUN with an empty FIFO.
    always_comb begin
        run_eff   = sync || (state_q == RUN);
        level_eff = sync ? '0 : level_q;
        wr_eff    = sync ? '0 : wr_q;
        rd_eff    = sync ? '0 : rd_q;
        empty     = (level_eff == '0);
        full      = (level_eff == (FB+1)'(DEPTH));
        push_req  = run_eff && corr_vld;
        pop_req   = run_eff && xeng_vld;
        bypass    = push_req && pop_req && empty;
        overflow  = push_req && !pop_req && full;
        underflow = pop_req && !push_req && empty;
        fault     = overflow || underflow;
        do_push   = push_req && !bypass && !overflow;
        do_pop    = pop_req && !bypass && !underflow;
        accept    = bypass || do_pop;
        corr_sel  = bypass ? corr_din : mem[rd_eff];
        level_d   = level_eff + (FB+1)'(do_push) - (FB+1)'(do_pop);
        state_d   = fault ? ERR : (sync ? RUN : state_q);
        err_d     = fault ? 1'b1 : (sync ? 1'b0 : err);
    end

    always_comb begin
        diff   = '0;
        raw_f  = '0;
        corr_f = '0;
        for (int i = 0; i < 8; i++) begin
            raw_f  = s1_raw_q[i*AW +: AW];
            corr_f = s1_corr_q[i*CW +: CW];
            diff[i*OW +: OW] = {raw_f[AW-1], raw_f} - {{(OW-CW){corr_f[CW-1]}}, corr_f};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_eff] <= corr_din;
    end

    // Pops accepted before a fault or sync still drain through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            err         <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            level_q     <= '0;
            sync_pipe_q <= '0;
            s1_vld_q    <= 1'b0;
            s1_raw_q    <= '0;
            s1_corr_q   <= '0;
            dout        <= '0;
            dout_vld    <= 1'b0;
        end else begin
            state_q     <= state_d;
            err         <= err_d;
            wr_q        <= do_push ? wr_eff + 1'b1 : wr_eff;
            rd_q        <= do_pop ? rd_eff + 1'b1 : rd_eff;
            level_q     <= level_d;
            sync_pipe_q <= {sync_pipe_q[0], sync};
            s1_vld_q    <= accept;
            if (accept) begin
                s1_raw_q  <= xeng_din;
                s1_corr_q <= corr_sel;
            end
            dout_vld <= s1_vld_q;
            if (s1_vld_q) dout <= diff;
        end
    end

    assign sync_out   = sync_pipe_q[1];
    assign fifo_level = level_q;
endmodule

// File: tb/tb_xeng_corr_apply.sv
// Directed bench for xeng_corr_apply: expected outputs are queued at issue time and a
// negedge monitor compares them (data and 2-cycle latency) whenever dout_vld is seen.
module tb_xeng_corr_apply;
    localparam int CW = 15;
    localparam int AW = 24;
    localparam int OW = 25;
    localparam int FB = 5;

    logic              clk = 1'b0;
    logic              rst_n, sync, corr_vld, xeng_vld;
    logic [8*CW-1:0]   corr_din;
    logic [8*AW-1:0]   xeng_din;
    logic [8*OW-1:0]   dout;
    logic              dout_vld, sync_out, err;
    logic [FB:0]       fifo_level;

    xeng_corr_apply #(.CORR_WIDTH(CW), .ACC_WIDTH(AW), .FIFO_DEPTH_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .corr_vld(corr_vld), .corr_din(corr_din),
        .xeng_vld(xeng_vld), .xeng_din(xeng_din), .dout(dout), .dout_vld(dout_vld),
        .sync_out(sync_out), .fifo_level(fifo_level), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct { logic [8*OW-1:0] d; int c; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [8*CW-1:0] pc(input int a, b, c, d, e, f, g, h);
        return {CW'(a), CW'(b), CW'(c), CW'(d), CW'(e), CW'(f), CW'(g), CW'(h)};
    endfunction
    function automatic logic [8*AW-1:0] pr(input int a, b, c, d, e, f, g, h);
        return {AW'(a), AW'(b), AW'(c), AW'(d), AW'(e), AW'(f), AW'(g), AW'(h)};
    endfunction
    function automatic logic [8*OW-1:0] pd(input int a, b, c, d, e, f, g, h);
        return {OW'(a), OW'(b), OW'(c), OW'(d), OW'(e), OW'(f), OW'(g), OW'(h)};
    endfunction

    task automatic chk(input string nm, input logic [8*OW-1:0] act, input logic [8*OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a posedge and sampled at the next posedge.
    task automatic cyc(input logic s, cv, xv, ev, input logic [8*CW-1:0] cd,
                       input logic [8*AW-1:0] xd, input logic [8*OW-1:0] ed);
        sync = s; corr_vld = cv; corr_din = cd; xeng_vld = xv; xeng_din = xd;
        if (ev) sb.push_back('{d: ed, c: cyc_cnt + 2});
        @(posedge clk); #1;
        sync = 1'b0; corr_vld = 1'b0; xeng_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dout_vld === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dout act=%h exp=none", dout);
            end else begin
                mon_e = sb.pop_front();
                chk("dout", dout, mon_e.d);
                chki("latency", cyc_cnt, mon_e.c);
            end
        end
    end

    initial begin
        sync = 1'b0; corr_vld = 1'b0; xeng_vld = 1'b0; corr_din = '0; xeng_din = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", dout, '0);
        chki("rst_dout_vld", int'(dout_vld), 0);
        chki("rst_sync_out", int'(sync_out), 0);
        chki("rst_level", int'(fifo_level), 0);
        chki("rst_err", int'(err), 0);
        rst_n = 1'b1;

        // IDLE ignores both strobes
        cyc(0, 1, 1, 0, pc(1,1,1,1,1,1,1,1), pr(9,9,9,9,9,9,9,9), '0);
        chki("idle_level", int'(fifo_level), 0);
        chki("idle_err", int'(err), 0);

        cyc(1, 0, 0, 0, '0, '0, '0);
        chki("sync_out_c1", int'(sync_out), 0);
        idle(1);
        chki("sync_out_c2", int'(sync_out), 1);
        idle(1);
        chki("sync_out_c3", int'(sync_out), 0);

        // 17 buffered corrections then 17 pops
        for (int k = 0; k < 17; k++) cyc(0, 1, 0, 0, pc(5,0,0,0,0,0,0,0), '0, '0);
        chki("level17", int'(fifo_level), 17);
        for (int k = 0; k < 17; k++) begin
            cyc(0, 0, 1, 1, '0, pr(100,0,-k,0,0,0,0,k), pd(95,0,-k,0,0,0,0,k));
            chki("level_drain", int'(fifo_level), 16 - k);
        end
        idle(3);
        chki("err_after_drain", int'(err), 0);

        // sign extension and full-width extremes
        cyc(0, 1, 0, 0, pc(-16384,16383,0,0,0,0,0,-3), '0, '0);
        cyc(0, 0, 1, 1, '0, pr(8388607,-8388608,0,0,0,0,0,-10),
            pd(8404991,-8404991,0,0,0,0,0,-7));
        idle(3);

        // bypass on empty FIFO
        cyc(0, 1, 1, 1, pc(0,1,0,0,0,0,0,0), pr(0,1,0,0,0,0,0,0), pd(0,0,0,0,0,0,0,0));
        chki("bypass_level", int'(fifo_level), 0);
        idle(2);
        chki("bypass_err", int'(err), 0);

        // fill, push+pop while full, then overflow
        for (int k = 0; k < 32; k++) cyc(0, 1, 0, 0, pc(0,0,0,k+1,0,0,0,0), '0, '0);
        chki("level_full", int'(fifo_level), 32);
        cyc(0, 1, 1, 1, pc(0,0,0,33,0,0,0,0), pr(0,0,0,50,0,0,0,0), pd(0,0,0,49,0,0,0,0));
        chki("full_pushpop_level", int'(fifo_level), 32);
        chki("full_pushpop_err", int'(err), 0);
        cyc(0, 1, 0, 0, pc(0,0,0,34,0,0,0,0), '0, '0);
        chki("ovf_err", int'(err), 1);
        chki("ovf_level", int'(fifo_level), 32);
        repeat (3) cyc(0, 0, 1, 0, '0, pr(3,3,3,3,3,3,3,3), '0);
        idle(2);
        chki("err_sticky", int'(err), 1);
        cyc(1, 0, 0, 0, '0, '0, '0);
        chki("ovf_sync_err", int'(err), 0);
        chki("ovf_sync_level", int'(fifo_level), 0);
        cyc(0, 1, 1, 1, pc(2,0,0,0,0,0,0,0), pr(-2,0,0,0,0,0,0,0), pd(-4,0,0,0,0,0,0,0));
        idle(3);

        // underflow, including one raised in the sync cycle itself
        cyc(1, 0, 1, 0, '0, pr(1,1,1,1,1,1,1,1), '0);
        chki("unf_sync_err", int'(err), 1);
        cyc(1, 0, 0, 0, '0, '0, '0);
        chki("unf_clear_err", int'(err), 0);
        cyc(0, 0, 1, 0, '0, pr(1,1,1,1,1,1,1,1), '0);
        chki("unf_err", int'(err), 1);
        idle(3);

        // async reset with a pop in flight
        cyc(1, 0, 0, 0, '0, '0, '0);
        for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 0, pc(0,0,0,0,k,0,0,0), '0, '0);
        cyc(0, 0, 1, 1, '0, pr(0,0,0,0,10,0,0,0), pd(0,0,0,0,9,0,0,0));
        idle(1);
        cyc(0, 0, 1, 1, '0, pr(0,0,0,0,10,0,0,0), pd(0,0,0,0,8,0,0,0));
        rst_n = 1'b0;
        #1;
        chk("arst_dout", dout, '0);
        chki("arst_dout_vld", int'(dout_vld), 0);
        chki("arst_level", int'(fifo_level), 0);
        chki("arst_err", int'(err), 0);
        chki("arst_sync_out", int'(sync_out), 0);
        sb.delete();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(0, 1, 1, 0, pc(1,1,1,1,1,1,1,1), pr(5,5,5,5,5,5,5,5), '0);
        chki("post_rst_level", int'(fifo_level), 0);
        chki("post_rst_err", int'(err), 0);
        idle(2);
        // sync with push+pop in the same cycle takes the bypass path
        cyc(1, 1, 1, 1, pc(0,0,0,0,0,0,7,0), pr(0,0,0,0,0,0,-7,0), pd(0,0,0,0,0,0,-14,0));
        chki("sync_bypass_level", int'(fifo_level), 0);
        idle(4);
        chki("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
